// File: rtl/wt_dcache_reuse_pred_pkg.sv
// Shared types and sizing for the dcache dead-on-arrival reuse predictor.
package wt_dcache_reuse_pred_pkg;
   localparam int DCACHE_NUM_WORDS    = 16;
   localparam int DCACHE_SET_ASSOC    = 4;
   localparam int DCACHE_CL_IDX_WIDTH = $clog2(DCACHE_NUM_WORDS);
   localparam int RP_WAY_WIDTH        = $clog2(DCACHE_SET_ASSOC);
   localparam int RP_SIG_WIDTH        = 8;

   typedef logic [1:0] rp_ctr_t;

   typedef struct packed {
      logic                    valid;
      logic                    reused;
      logic [RP_SIG_WIDTH-1:0] sig;
   } rp_meta_t;

   localparam rp_ctr_t RP_DEAD     = 2'd3;
   localparam rp_ctr_t RP_CTR_INIT = 2'd1;
endpackage

// File: rtl/wt_dcache_reuse_pred_if.sv
// Event and prediction bundle between the dcache controller and the reuse predictor.
interface wt_dcache_reuse_pred_if;
   import wt_dcache_reuse_pred_pkg::*;

   logic                           flush_i;
   logic                           req_i;
   logic [RP_SIG_WIDTH-1:0]        req_sig_i;
   logic                           pred_valid_o;
   rp_ctr_t                        pred_result_o;
   logic                           fill_i;
   logic [DCACHE_CL_IDX_WIDTH-1:0] fill_idx_i;
   logic [RP_WAY_WIDTH-1:0]        fill_way_i;
   logic [RP_SIG_WIDTH-1:0]        fill_sig_i;
   logic                           hit_i;
   logic [DCACHE_CL_IDX_WIDTH-1:0] hit_idx_i;
   logic [RP_WAY_WIDTH-1:0]        hit_way_i;

   modport slave (
      input  flush_i, req_i, req_sig_i, fill_i, fill_idx_i, fill_way_i, fill_sig_i,
             hit_i, hit_idx_i, hit_way_i,
      output pred_valid_o, pred_result_o
   );

   modport master (
      output flush_i, req_i, req_sig_i, fill_i, fill_idx_i, fill_way_i, fill_sig_i,
             hit_i, hit_idx_i, hit_way_i,
      input  pred_valid_o, pred_result_o
   );
endinterface

// File: rtl/wt_dcache_rp_table.sv
// Saturating 2-bit counter table: one async read port, one increment and one decrement port.
module wt_dcache_rp_table
   import wt_dcache_reuse_pred_pkg::*;
#(
   parameter int      SIG_WIDTH = RP_SIG_WIDTH,
   parameter rp_ctr_t CTR_INIT  = RP_CTR_INIT
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 flush_i,
   input  logic [SIG_WIDTH-1:0] rd_sig_i,
   output rp_ctr_t              rd_ctr_o,
   input  logic                 inc_en_i,
   input  logic [SIG_WIDTH-1:0] inc_sig_i,
   input  logic                 dec_en_i,
   input  logic [SIG_WIDTH-1:0] dec_sig_i
);
   localparam int DEPTH = 2**SIG_WIDTH;

   rp_ctr_t          r_ctr [DEPTH];
   logic [DEPTH-1:0] w_inc;
   logic [DEPTH-1:0] w_dec;

   assign rd_ctr_o = r_ctr[rd_sig_i];

   always_comb begin
      w_inc = '0;
      w_dec = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_inc[i] = inc_en_i && (inc_sig_i == SIG_WIDTH'(i));
         w_dec[i] = dec_en_i && (dec_sig_i == SIG_WIDTH'(i));
      end
   end

   // an increment and a decrement landing on one entry cancel out
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) r_ctr[i] <= CTR_INIT;
      end else if (flush_i) begin
         for (int i = 0; i < DEPTH; i++) r_ctr[i] <= CTR_INIT;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (w_inc[i] && !w_dec[i] && r_ctr[i] != RP_DEAD)
               r_ctr[i] <= r_ctr[i] + 2'd1;
            else if (w_dec[i] && !w_inc[i] && r_ctr[i] != 2'd0)
               r_ctr[i] <= r_ctr[i] - 2'd1;
         end
      end
   end
endmodule

// File: rtl/wt_dcache_reuse_pred.sv
// Reuse predictor top: per-line metadata, training decode and the held prediction for the PLRU.
module wt_dcache_reuse_pred
   import wt_dcache_reuse_pred_pkg::*;
#(
   parameter int      SIG_WIDTH = RP_SIG_WIDTH,
   parameter int      NUM_SETS  = DCACHE_NUM_WORDS,
   parameter int      NUM_WAYS  = DCACHE_SET_ASSOC,
   parameter rp_ctr_t CTR_INIT  = RP_CTR_INIT
) (
   input logic                 clk_i,
   input logic                 rst_ni,
   wt_dcache_reuse_pred_if.slave bus
);
   rp_meta_t r_meta [NUM_SETS][NUM_WAYS];
   logic     r_pred_valid;
   rp_ctr_t  r_pred_result;

   rp_meta_t w_fill_meta;
   rp_meta_t w_hit_meta;
   logic     w_fill_ok;
   logic     w_hit_ok;
   logic     w_inc_en;
   logic     w_dec_en;
   rp_ctr_t  w_rd_ctr;

   always_comb begin
      w_fill_meta = r_meta[bus.fill_idx_i][bus.fill_way_i];
      w_hit_meta  = r_meta[bus.hit_idx_i][bus.hit_way_i];
      w_fill_ok   = bus.fill_i && (32'(bus.fill_idx_i) < NUM_SETS);
      // a fill replacing the line being hit makes that hit meaningless
      w_hit_ok    = bus.hit_i && (32'(bus.hit_idx_i) < NUM_SETS) &&
                    !(w_fill_ok && bus.fill_idx_i == bus.hit_idx_i &&
                      bus.fill_way_i == bus.hit_way_i);
      w_inc_en    = w_fill_ok && w_fill_meta.valid && !w_fill_meta.reused;
      w_dec_en    = w_hit_ok && w_hit_meta.valid && !w_hit_meta.reused;
   end

   wt_dcache_rp_table #(
      .SIG_WIDTH (SIG_WIDTH),
      .CTR_INIT  (CTR_INIT)
   ) u_table (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .flush_i   (bus.flush_i),
      .rd_sig_i  (bus.req_sig_i),
      .rd_ctr_o  (w_rd_ctr),
      .inc_en_i  (w_inc_en),
      .inc_sig_i (w_fill_meta.sig),
      .dec_en_i  (w_dec_en),
      .dec_sig_i (w_hit_meta.sig)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int s = 0; s < NUM_SETS; s++)
            for (int w = 0; w < NUM_WAYS; w++) r_meta[s][w] <= '0;
      end else if (bus.flush_i) begin
         for (int s = 0; s < NUM_SETS; s++)
            for (int w = 0; w < NUM_WAYS; w++) r_meta[s][w] <= '0;
      end else begin
         if (w_dec_en) r_meta[bus.hit_idx_i][bus.hit_way_i].reused <= 1'b1;
         if (w_fill_ok)
            r_meta[bus.fill_idx_i][bus.fill_way_i] <= '{valid: 1'b1, reused: 1'b0,
                                                         sig: bus.fill_sig_i};
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_pred_valid  <= 1'b0;
         r_pred_result <= 2'd0;
      end else if (bus.flush_i) begin
         r_pred_valid  <= 1'b0;
         r_pred_result <= 2'd0;
      end else if (bus.req_i) begin
         r_pred_valid  <= 1'b1;
         r_pred_result <= w_rd_ctr;
      end else if (bus.fill_i) begin
         r_pred_valid  <= 1'b0;
      end
   end

   assign bus.pred_valid_o  = r_pred_valid;
   assign bus.pred_result_o = r_pred_result;
endmodule

// File: tb/tb_wt_dcache_reuse_pred.sv
// Scoreboard bench for the reuse predictor: a behavioural model queues expected lookup results.
module tb_wt_dcache_reuse_pred;
   import wt_dcache_reuse_pred_pkg::*;

   logic clk_i = 1'b0;
   logic rst_ni;
   always #5 clk_i = ~clk_i;

   wt_dcache_reuse_pred_if tif ();

   wt_dcache_reuse_pred u_dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .bus    (tif.slave)
   );

   int total = 0;
   int bad   = 0;

   int       m_ctr [256];
   bit       m_val [16][4];
   bit       m_reu [16][4];
   bit [7:0] m_sig [16][4];
   bit       exp_valid;
   int       exp_held;
   int       q_pred [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   function automatic int clamp(input int v);
      return (v < 0) ? 0 : (v > 3) ? 3 : v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 256; i++) m_ctr[i] = 1;
      for (int s = 0; s < 16; s++)
         for (int w = 0; w < 4; w++) begin
            m_val[s][w] = 0; m_reu[s][w] = 0; m_sig[s][w] = 0;
         end
      exp_valid = 0;
      exp_held  = 0;
   endtask

   task automatic clear_inputs();
      tif.flush_i = 0; tif.req_i = 0; tif.req_sig_i = 0;
      tif.fill_i = 0; tif.fill_idx_i = 0; tif.fill_way_i = 0; tif.fill_sig_i = 0;
      tif.hit_i = 0; tif.hit_idx_i = 0; tif.hit_way_i = 0;
   endtask

   // one clock: model the driven event, advance, then check the DUT
   task automatic step();
      int  fi, fw, hi, hw, sg;
      bit  fok, hok, did_req, did_flush;
      int  tmp [256];
      did_req   = tif.req_i && !tif.flush_i;
      did_flush = tif.flush_i;
      if (did_flush) begin
         model_reset();
      end else begin
         if (did_req) q_pred.push_back(m_ctr[tif.req_sig_i]);
         tmp = m_ctr;
         fi = int'(tif.fill_idx_i); fw = int'(tif.fill_way_i);
         hi = int'(tif.hit_idx_i);  hw = int'(tif.hit_way_i);
         fok = tif.fill_i;
         hok = tif.hit_i && !(fok && fi == hi && fw == hw);
         if (fok && m_val[fi][fw] && !m_reu[fi][fw]) begin
            sg = m_sig[fi][fw]; tmp[sg] = tmp[sg] + 1;
         end
         if (hok && m_val[hi][hw] && !m_reu[hi][hw]) begin
            sg = m_sig[hi][hw]; tmp[sg] = tmp[sg] - 1;
            m_reu[hi][hw] = 1;
         end
         if (fok) begin
            m_val[fi][fw] = 1; m_reu[fi][fw] = 0; m_sig[fi][fw] = tif.fill_sig_i;
         end
         for (int i = 0; i < 256; i++) m_ctr[i] = clamp(tmp[i]);
         if (did_req) exp_valid = 1;
         else if (fok) exp_valid = 0;
      end
      @(posedge clk_i);
      #1;
      chk("pred_valid", tif.pred_valid_o, exp_valid);
      if (did_req) begin
         if (q_pred.size() == 0) chk("queue_empty", 1, 0);
         else exp_held = q_pred.pop_front();
      end
      chk(did_req ? "pred_result" : "pred_held", tif.pred_result_o, exp_held);
      clear_inputs();
   endtask

   task automatic lookup(input int sig);
      tif.req_i = 1; tif.req_sig_i = sig[7:0]; step();
   endtask

   task automatic do_fill(input int idx, input int way, input int sig);
      tif.fill_i = 1; tif.fill_idx_i = idx[3:0]; tif.fill_way_i = way[1:0];
      tif.fill_sig_i = sig[7:0]; step();
   endtask

   task automatic do_hit(input int idx, input int way);
      tif.hit_i = 1; tif.hit_idx_i = idx[3:0]; tif.hit_way_i = way[1:0]; step();
   endtask

   task automatic check_all_init(input string tag);
      for (int i = 0; i < 256; i++) begin
         lookup(i);
         chk(tag, tif.pred_result_o, 1);
      end
   endtask

   initial begin
      clear_inputs();
      model_reset();
      rst_ni = 0;
      repeat (2) @(posedge clk_i);
      #1;
      chk("rst_valid", tif.pred_valid_o, 0);
      chk("rst_result", tif.pred_result_o, 0);
      rst_ni = 1;

      lookup('h12);
      chk("first_lookup", tif.pred_result_o, 1);

      // eviction training and saturation at 3
      for (int r = 0; r < 3; r++) begin
         do_fill(5, 2, 'h12);
         do_fill(5, 2, 'h34);
      end
      lookup('h12);
      chk("sat_high", tif.pred_result_o, 3);

      // first hit decrements once; reused line evicts without increment
      do_fill(7, 0, 'h40);
      do_hit(7, 0);
      do_hit(7, 0);
      lookup('h40);
      chk("one_dec", tif.pred_result_o, 0);
      do_fill(7, 0, 'h41);
      lookup('h40);
      chk("no_inc_reused", tif.pred_result_o, 0);
      do_fill(8, 0, 'h40);
      do_hit(8, 0);
      lookup('h40);
      chk("sat_low", tif.pred_result_o, 0);
      do_hit(9, 0);

      // inc and dec on the same counter in one cycle cancel
      do_fill(1, 1, 'h0A);
      do_fill(2, 3, 'h0A);
      tif.hit_i = 1; tif.hit_idx_i = 1; tif.hit_way_i = 1;
      tif.fill_i = 1; tif.fill_idx_i = 2; tif.fill_way_i = 3; tif.fill_sig_i = 'h55;
      step();
      lookup('h0A);
      chk("net_zero", tif.pred_result_o, 1);

      // fill and hit on one line: fill wins, old unreused sig still trains
      do_fill(3, 1, 'h60);
      tif.hit_i = 1; tif.hit_idx_i = 3; tif.hit_way_i = 1;
      tif.fill_i = 1; tif.fill_idx_i = 3; tif.fill_way_i = 1; tif.fill_sig_i = 'h61;
      step();
      do_hit(3, 1);
      lookup('h60);
      chk("fh_old_inc", tif.pred_result_o, 2);
      lookup('h61);
      chk("fh_new_unreused", tif.pred_result_o, 0);
      do_fill(3, 2, 'h70);
      do_hit(3, 2);
      tif.hit_i = 1; tif.hit_idx_i = 3; tif.hit_way_i = 2;
      tif.fill_i = 1; tif.fill_idx_i = 3; tif.fill_way_i = 2; tif.fill_sig_i = 'h71;
      step();
      lookup('h70);
      chk("fh_old_reused", tif.pred_result_o, 0);

      // lookup sees the pre-update value while the entry trains; req keeps valid over fill
      do_fill(4, 0, 'h80);
      tif.req_i = 1; tif.req_sig_i = 'h80;
      tif.fill_i = 1; tif.fill_idx_i = 4; tif.fill_way_i = 0; tif.fill_sig_i = 'h81;
      step();
      chk("pre_update", tif.pred_result_o, 1);
      lookup('h80);
      chk("post_update", tif.pred_result_o, 2);

      // flush beats a concurrent request
      do_fill(6, 1, 'h90);
      tif.flush_i = 1; tif.req_i = 1; tif.req_sig_i = 'h12;
      tif.fill_i = 1; tif.fill_idx_i = 6; tif.fill_way_i = 1; tif.fill_sig_i = 'h91;
      step();
      chk("flush_valid", tif.pred_valid_o, 0);
      check_all_init("flush_init");
      do_fill(6, 1, 'h22);
      lookup('h90);
      chk("flush_meta", tif.pred_result_o, 1);

      // async reset in the middle of a fill cycle
      do_fill(10, 0, 'h33);
      do_fill(10, 0, 'h44);
      tif.fill_i = 1; tif.fill_idx_i = 10; tif.fill_way_i = 0; tif.fill_sig_i = 'h55;
      #2 rst_ni = 0;
      #1;
      chk("arst_valid", tif.pred_valid_o, 0);
      chk("arst_result", tif.pred_result_o, 0);
      clear_inputs();
      #1 rst_ni = 1;
      model_reset();
      q_pred.delete();
      check_all_init("arst_init");
      do_fill(10, 0, 'h66);
      lookup('h44);
      chk("arst_meta", tif.pred_result_o, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
